// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing with pixel requests and latency-matched sync/RGB pins
module vga_timing_ctrl #(
   parameter int PIX_LATENCY = 1,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int H_ACT       = 640,
   parameter int H_FP        = 16,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int V_ACT       = 480,
   parameter int V_FP        = 10
) (
   input  logic        vga_clk,
   input  logic        rst_sys_n,
   input  logic [11:0] pix_data,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic        req_valid,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_B   = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_ACT_E   = HW'(H_SYNC + H_BP + H_ACT);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_B   = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_ACT_E   = VW'(V_SYNC + V_BP + V_ACT);

   logic [HW-1:0]          h_cnt_q, h_cnt_d;
   logic [VW-1:0]          v_cnt_q, v_cnt_d;
   logic                   h_last, v_last, h_act, v_act, hsync_raw, vsync_raw;
   logic [PIX_LATENCY-1:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic                   hsync_q, vsync_q, frame_start_q, frame_start_d;
   logic [11:0]            rgb_q, rgb_d;

   // Decode raster position, form the request and compute next counter values
   always_comb begin
      h_last    = h_cnt_q == H_LAST;
      v_last    = v_cnt_q == V_LAST;
      h_cnt_d   = h_last ? '0 : h_cnt_q + 1'b1;
      v_cnt_d   = !h_last ? v_cnt_q : v_last ? '0 : v_cnt_q + 1'b1;
      h_act     = h_cnt_q >= H_ACT_B && h_cnt_q < H_ACT_E;
      v_act     = v_cnt_q >= V_ACT_B && v_cnt_q < V_ACT_E;
      hsync_raw = h_cnt_q >= H_SYNC_E;
      vsync_raw = v_cnt_q >= V_SYNC_E;
      req_valid = h_act && v_act;
      x         = req_valid ? 10'(h_cnt_q - H_ACT_B) : '0;
      y         = req_valid ? 9'(v_cnt_q - V_ACT_B) : '0;
   end

   // Shift sync/enable so they meet the renderer's pixel, then gate RGB by the delayed enable
   always_comb begin
      hs_d          = PIX_LATENCY'({hs_q, hsync_raw});
      vs_d          = PIX_LATENCY'({vs_q, vsync_raw});
      de_d          = PIX_LATENCY'({de_q, req_valid});
      rgb_d         = de_q[PIX_LATENCY-1] ? pix_data : 12'h000;
      frame_start_d = h_last && v_last;
   end

   // Raster counters; a reset always restarts the frame at (0,0)
   always_ff @(posedge vga_clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Display pipeline and pin registers; sync idles high and RGB blank while in reset
   always_ff @(posedge vga_clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         hs_q          <= '1;
         vs_q          <= '1;
         de_q          <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= 12'h000;
         frame_start_q <= 1'b0;
      end else begin
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         de_q          <= de_d;
         hsync_q       <= hs_q[PIX_LATENCY-1];
         vsync_q       <= vs_q[PIX_LATENCY-1];
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync                 = hsync_q;
   assign vsync                 = vsync_q;
   assign {vga_r, vga_g, vga_b} = rgb_q;
   assign frame_start           = frame_start_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for three reduced-geometry DUTs and one full 640x480 DUT
module tb_vga_timing_ctrl;
   localparam int SHS = 4, SHB = 3, SHA = 10, SHF = 3;
   localparam int SVS = 2, SVB = 2, SVA = 8, SVF = 2;

   typedef struct {
      int hs; int hb; int ha; int hf;
      int vs; int vb; int va; int vf;
      int lat; bit solid;
   } geo_t;

   typedef struct {
      bit req; int x; int y; bit hs; bit vs; logic [11:0] rgb; bit fs;
   } exp_t;

   logic        vga_clk = 1'b0;
   logic        rst_sys_n;
   logic [11:0] pix_w[4];
   logic [9:0]  x_w[4];
   logic [8:0]  y_w[4];
   logic        req_w[4], hs_w[4], vs_w[4], fs_w[4];
   logic [3:0]  r_w[4], g_w[4], b_w[4];
   logic [11:0] pa, pd;
   logic [11:0] pb[3];

   geo_t g[4];
   exp_t q[4][$];
   int   t, phase, checks, errors;
   int   hl_a, vl_a, rq_a, nz_a, hl_d, vl_d, first_d, fs_n, fs_last;

   vga_timing_ctrl #(.PIX_LATENCY(1), .H_SYNC(SHS), .H_BP(SHB), .H_ACT(SHA), .H_FP(SHF),
                     .V_SYNC(SVS), .V_BP(SVB), .V_ACT(SVA), .V_FP(SVF)) u_a (
      .vga_clk(vga_clk), .rst_sys_n(rst_sys_n), .pix_data(pix_w[0]), .x(x_w[0]), .y(y_w[0]),
      .req_valid(req_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .vga_r(r_w[0]), .vga_g(g_w[0]),
      .vga_b(b_w[0]), .frame_start(fs_w[0]));

   vga_timing_ctrl #(.PIX_LATENCY(3), .H_SYNC(SHS), .H_BP(SHB), .H_ACT(SHA), .H_FP(SHF),
                     .V_SYNC(SVS), .V_BP(SVB), .V_ACT(SVA), .V_FP(SVF)) u_b (
      .vga_clk(vga_clk), .rst_sys_n(rst_sys_n), .pix_data(pix_w[1]), .x(x_w[1]), .y(y_w[1]),
      .req_valid(req_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .vga_r(r_w[1]), .vga_g(g_w[1]),
      .vga_b(b_w[1]), .frame_start(fs_w[1]));

   vga_timing_ctrl #(.PIX_LATENCY(2), .H_SYNC(SHS), .H_BP(SHB), .H_ACT(SHA), .H_FP(SHF),
                     .V_SYNC(SVS), .V_BP(SVB), .V_ACT(SVA), .V_FP(SVF)) u_c (
      .vga_clk(vga_clk), .rst_sys_n(rst_sys_n), .pix_data(pix_w[2]), .x(x_w[2]), .y(y_w[2]),
      .req_valid(req_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .vga_r(r_w[2]), .vga_g(g_w[2]),
      .vga_b(b_w[2]), .frame_start(fs_w[2]));

   vga_timing_ctrl #(.PIX_LATENCY(1)) u_d (
      .vga_clk(vga_clk), .rst_sys_n(rst_sys_n), .pix_data(pix_w[3]), .x(x_w[3]), .y(y_w[3]),
      .req_valid(req_w[3]), .hsync(hs_w[3]), .vsync(vs_w[3]), .vga_r(r_w[3]), .vga_g(g_w[3]),
      .vga_b(b_w[3]), .frame_start(fs_w[3]));

   always #20 vga_clk = ~vga_clk;

   // Cycles since reset release: cycle 0 is the one in which the counters sit at (0,0)
   always @(posedge vga_clk or negedge rst_sys_n) t <= !rst_sys_n ? 0 : t + 1;

   // Renderer models answering each request with {x[3:0],y[3:0],A} after exactly PIX_LATENCY
   always @(posedge vga_clk) begin
      pa    <= {x_w[0][3:0], y_w[0][3:0], 4'hA};
      pb[0] <= {x_w[1][3:0], y_w[1][3:0], 4'hA};
      pb[1] <= pb[0];
      pb[2] <= pb[1];
      pd    <= {x_w[3][3:0], y_w[3][3:0], 4'hA};
   end
   assign pix_w[0] = pa;
   assign pix_w[1] = pb[2];
   assign pix_w[2] = 12'hFFF;
   assign pix_w[3] = pd;

   function automatic geo_t mk(input int hs, hb, ha, hf, vs, vb, va, vf, lat, input bit solid);
      geo_t r;
      r.hs = hs; r.hb = hb; r.ha = ha; r.hf = hf;
      r.vs = vs; r.vb = vb; r.va = va; r.vf = vf;
      r.lat = lat; r.solid = solid;
      return r;
   endfunction

   // Expected outputs for cycle tt after release, derived from the cycle index alone
   function automatic exp_t model(input geo_t gg, input int tt);
      exp_t e;
      int ht, vt, hc, vc, hb0, vb0;
      ht  = gg.hs + gg.hb + gg.ha + gg.hf;
      vt  = gg.vs + gg.vb + gg.va + gg.vf;
      hc  = tt % ht;
      vc  = (tt / ht) % vt;
      hb0 = gg.hs + gg.hb;
      vb0 = gg.vs + gg.vb;
      e.req = hc >= hb0 && hc < hb0 + gg.ha && vc >= vb0 && vc < vb0 + gg.va;
      e.x   = e.req ? hc - hb0 : 0;
      e.y   = e.req ? vc - vb0 : 0;
      e.hs  = hc >= gg.hs;
      e.vs  = vc >= gg.vs;
      e.rgb = !e.req ? 12'h000 : gg.solid ? 12'hFFF : 12'((e.x % 16) * 256 + (e.y % 16) * 16 + 10);
      e.fs  = tt > 0 && hc == 0 && vc == 0;
      return e;
   endfunction

   task automatic chk(input int k, input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s dut%0d t=%0d got 0x%0h expected 0x%0h", n, k, t, a, e);
      end
   endtask

   // Monitor: compare request outputs now, pin outputs against the queued expectation
   always @(negedge vga_clk) begin
      exp_t e, p;
      for (int k = 0; k < 4; k++) begin
         if (!rst_sys_n) begin
            chk(k, "rst_x", x_w[k], 0);
            chk(k, "rst_y", y_w[k], 0);
            chk(k, "rst_req", req_w[k], 0);
            chk(k, "rst_hsync", hs_w[k], 1);
            chk(k, "rst_vsync", vs_w[k], 1);
            chk(k, "rst_rgb", {r_w[k], g_w[k], b_w[k]}, 0);
            chk(k, "rst_fs", fs_w[k], 0);
            e.req = 0; e.x = 0; e.y = 0; e.hs = 1; e.vs = 1; e.rgb = 12'h000; e.fs = 0;
            q[k].delete();
            repeat (g[k].lat + 1) q[k].push_back(e);
         end else begin
            e = model(g[k], t);
            chk(k, "req_valid", req_w[k], e.req);
            chk(k, "x", x_w[k], e.x);
            chk(k, "y", y_w[k], e.y);
            chk(k, "frame_start", fs_w[k], e.fs);
            q[k].push_back(e);
            p = q[k].pop_front();
            chk(k, "hsync", hs_w[k], p.hs);
            chk(k, "vsync", vs_w[k], p.vs);
            chk(k, "rgb", {r_w[k], g_w[k], b_w[k]}, p.rgb);
         end
      end
      if (rst_sys_n && phase == 1) begin
         if (t >= 2 && t < 282) begin
            hl_a += int'(!hs_w[0]);
            vl_a += int'(!vs_w[0]);
            nz_a += int'({r_w[0], g_w[0], b_w[0]} != 12'h000);
         end
         if (t < 280) rq_a += int'(req_w[0]);
         if (t >= 2 && t < 28002) begin
            hl_d += int'(!hs_w[3]);
            vl_d += int'(!vs_w[3]);
         end
         if (req_w[3] && first_d < 0) first_d = t;
         if (t == 234) chk(0, "pix_5_7", {r_w[0], g_w[0], b_w[0]}, 12'h57A);
         if (t == 236) chk(1, "pix_5_7", {r_w[1], g_w[1], b_w[1]}, 12'h57A);
      end
      if (rst_sys_n && phase == 2 && fs_w[0]) begin
         if (fs_n == 0) chk(0, "fs_first", t, 280);
         else chk(0, "fs_gap", t - fs_last, 280);
         fs_n++;
         fs_last = t;
      end
   end

   initial begin
      g[0] = mk(SHS, SHB, SHA, SHF, SVS, SVB, SVA, SVF, 1, 1'b0);
      g[1] = mk(SHS, SHB, SHA, SHF, SVS, SVB, SVA, SVF, 3, 1'b0);
      g[2] = mk(SHS, SHB, SHA, SHF, SVS, SVB, SVA, SVF, 2, 1'b1);
      g[3] = mk(96, 48, 640, 16, 2, 33, 480, 10, 1, 1'b0);
      checks = 0; errors = 0; phase = 0;
      hl_a = 0; vl_a = 0; rq_a = 0; nz_a = 0; hl_d = 0; vl_d = 0;
      first_d = -1; fs_n = 0; fs_last = 0;
      rst_sys_n = 1'b0;
      repeat (5) @(posedge vga_clk);
      #1 rst_sys_n = 1'b1;
      phase = 1;
      while (t != 28412) @(negedge vga_clk);
      #1;
      chk(0, "hs_low_frame", hl_a, 56);
      chk(0, "vs_low_frame", vl_a, 40);
      chk(0, "req_per_frame", rq_a, 80);
      chk(0, "lit_per_frame", nz_a, 80);
      chk(3, "hs_low_35_lines", hl_d, 3360);
      chk(3, "vs_low_frame", vl_d, 1600);
      chk(3, "first_req_t", first_d, 28144);
      #1 rst_sys_n = 1'b0;
      phase = 0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk(k, "midrst_rgb", {r_w[k], g_w[k], b_w[k]}, 0);
         chk(k, "midrst_hsync", hs_w[k], 1);
         chk(k, "midrst_vsync", vs_w[k], 1);
      end
      repeat (3) @(posedge vga_clk);
      #1 rst_sys_n = 1'b1;
      phase = 2;
      while (t != 850) @(negedge vga_clk);
      #1;
      chk(0, "fs_count", fs_n, 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA raster timing and issues per-pixel coordinate requests (x, y) to the pixel renderer (draw stage).
- Accepts the renderer's registered 12-bit pixel back after a fixed pipeline latency.
- Drives hsync, vsync and the 4:4:4 RGB pins, blanked outside the active window.
- Sits between the 25 MHz pixel clock domain root and the board VGA connector.

Parameters:
PIX_LATENCY, 1, cycles from an x/y request to the matching pix_data; legal range 1..4
H_SYNC, 96, hsync pulse width in pixel clocks
H_BP, 48, horizontal back porch
H_ACT, 640, horizontal active pixels
H_FP, 16, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch
V_ACT, 480, vertical active lines
V_FP, 10, vertical front porch

Ports:
vga_clk  in  1  pixel clock (25 MHz)
rst_sys_n  in  1  asynchronous reset, active-low
pix_data  in  12  RGB444 pixel from renderer, {R[11:8],G[7:4],B[3:0]}
x  out  10  requested pixel column, 0..639
y  out  9  requested pixel row, 0..479
req_valid  out  1  x/y lie in the active window
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
vga_r  out  4  red pin
vga_g  out  4  green pin
vga_b  out  4  blue pin
frame_start  out  1  one-cycle pulse at each frame rollover

Behaviour:
- Counters and totals:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = sum of the four H parameters (800).
  - v_cnt runs 0..V_TOTAL-1, with V_TOTAL = 525.
  - v_cnt increments only when h_cnt wraps from 799 to 0; v_cnt wraps from 524 to 0 on that same edge.
- Regions (h, then v):
  - Sync: h 0..95, v 0..1.
  - Back porch: h 96..143, v 2..34.
  - Active: h 144..783, v 35..514.
  - Front porch: h 784..799, v 515..524.
- Request stage (lead), a function of the registered counters only:
  - req_valid = h_active AND v_active.
  - x = h_cnt-144 when req_valid, else 0.
  - y = v_cnt-35 when req_valid, else 0.
  - Arithmetic is done at full counter width, then truncated to the port width.
- Display stage (lag):
  - hsync_raw, vsync_raw and req_valid pass through PIX_LATENCY register stages.
  - The final stage drives hsync, vsync and de.
  - Hence sync and blanking on the pins align with pix_data for the same coordinate.
- RGB:
  - Registered on vga_clk.
  - When de=1, {vga_r,vga_g,vga_b} <= pix_data; when de=0, it is 0.
  - Net pin latency from request = PIX_LATENCY+1. hsync and vsync also pass through one extra register so they match that latency exactly.
- frame_start: registered; high for exactly one cycle on the clock edge where the counters go from (799,524) to (0,0). It is not asserted on reset release.
- Reset (rst_sys_n=0, asynchronous assert, synchronous-release behaviour via flops):
  - h_cnt=0, v_cnt=0.
  - All delay stages: hsync/vsync=1, de=0.
  - Outputs: vga_r/g/b=0, frame_start=0, x=0, y=0, req_valid=0.
  - Counting starts on the first rising vga_clk after release, at (0,0), i.e. in the sync region.
- Reset mid-frame: outputs take their reset values immediately and combinationally via the async clear. On release the frame restarts at (0,0); no partial-line carry-over.
- pix_data is ignored (pins forced to 0) whenever the delayed de=0, including the first PIX_LATENCY cycles after reset.
- No backpressure: the renderer must meet PIX_LATENCY exactly; the controller never stalls.

Test Plan:
- Reset then release, PIX_LATENCY=1, 1 frame: hsync low for exactly 96 clocks every 800. Vsync low for exactly 1600 clocks (2 lines) every 420000. Pins show hsync=1 and vsync=1 until the first counted sync cycle.
- Request window check: the first req_valid=1 occurs at h_cnt=144, v_cnt=35 with x=0, y=0. The last occurs at x=639, y=479. Exactly 307200 req_valid cycles per frame.
- Latency alignment: drive pix_data = {x[3:0], y[3:0], 4'hA} delayed by PIX_LATENCY in a bench model. The pin RGB for active pixel (5,7) must equal 12'h57A, two cycles after that request (PIX_LATENCY=1). Repeat with PIX_LATENCY=3 and a 4-cycle offset.
- Blanking: hold pix_data=12'hFFF constantly. The RGB pins must read 0 throughout h porches/sync and v blank lines, and 12'hFFF on every active pixel.
- frame_start: over 3 frames, exactly 3 pulses, 420000 clocks apart, none on reset release.
- Mid-frame reset: assert rst_sys_n=0 at h=400, v=200 for 3 clocks. The pins immediately read rgb=0, hsync=1, vsync=1. After release, the counters restart at (0,0) and the next frame_start comes 420000 clocks later.
